// File: rtl/serial_tx_feeder.sv
// -----------------------------------------------------------------------------
// serial_tx_feeder
//
// Byte FIFO that feeds a serial transmitter one byte at a time. Bytes written
// on wr_en are queued in a circular buffer; a small FSM pops the head byte
// whenever the transmitter is idle, presents it on tx_data with a one-cycle
// tx_start pulse, waits for tx_busy to rise (bounded by BUSY_TIMEOUT cycles)
// and then waits for tx_busy to fall before the next byte.
//
// Parameters
//   DEPTH_LOG2   : log2 of the FIFO depth (default 4 -> 16 bytes)
//   BUSY_TIMEOUT : cycles allowed for tx_busy to rise after a start
//
// Ports
//   clk        in   single clock, everything on the rising edge
//   rst        in   synchronous active-high reset
//   wr_en      in   write strobe, one byte per cycle
//   wr_data    in   byte to queue
//   full       out  FIFO holds 2^DEPTH_LOG2 bytes
//   empty      out  FIFO holds no bytes
//   count      out  number of bytes queued
//   overflow   out  sticky, a write was dropped because the FIFO was full
//   tx_start   out  one-cycle start pulse to the transmitter
//   tx_data    out  byte to the transmitter, held until the next start
//   tx_busy    in   transmitter busy, rises the cycle after an accepted start
//   tx_timeout out  sticky, tx_busy did not rise within BUSY_TIMEOUT cycles
// -----------------------------------------------------------------------------
module serial_tx_feeder #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic                  tx_timeout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;
    // Timeout counter only needs to reach BUSY_TIMEOUT-1.
    localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [TW-1:0] TO_ZERO  = TW'(0);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic            full_r;
    logic            empty_r;
    logic            overflow_r;
    logic            tx_start_r;
    logic [7:0]      tx_data_r;
    logic            tx_timeout_r;
    logic [TW-1:0]   to_cnt_r;
    logic [7:0]      mem_r [DEPTH];
    logic            push_s;
    logic            pop_s;

    assign full       = full_r;
    assign empty      = empty_r;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign tx_timeout = tx_timeout_r;

    // Push/pop qualification. A write into a full FIFO is never accepted,
    // even if a pop frees a slot on the same edge.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (wr_en && !full_r) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && !empty_r && !tx_busy) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Occupancy after this edge's push/pop; full/empty are derived from it
    // so the registered flags always agree with the registered count.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Byte storage; no reset needed because count/empty gate every read.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy flags and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == CNT_ZERO);
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmit handshake FSM with registered start/data/timeout outputs.
    // tx_data only changes on a pop, which happens only in IDLE, so it stays
    // stable for the whole busy period of the transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            tx_timeout_r <= 1'b0;
            to_cnt_r     <= TO_ZERO;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_r  <= mem_r[rd_ptr_r];
                        tx_start_r <= 1'b1;
                        to_cnt_r   <= TO_ZERO;
                        state_r    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        to_cnt_r <= TO_ZERO;
                        state_r  <= ST_WAIT_DONE;
                    end else if (to_cnt_r == TO_LAST) begin
                        // Transmitter never acknowledged; the popped byte is lost.
                        tx_timeout_r <= 1'b1;
                        to_cnt_r     <= TO_ZERO;
                        state_r      <= ST_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    to_cnt_r <= TO_ZERO;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_feeder
//
// Scoreboard bench: every accepted write pushes its byte onto exp_q; a monitor
// pops and compares on every tx_start. A behavioural transmitter drives tx_busy
// (either responding to starts for busy_len cycles, or forced to a level).
// -----------------------------------------------------------------------------
module tb_serial_tx_feeder;

    localparam int DEPTH_LOG2   = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy = 1'b0;
    logic                tx_timeout;

    int         assert_count = 0;
    int         fail_count   = 0;
    int         start_count  = 0;
    int         max_count    = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_data    = 8'h00;

    // Transmitter model controls
    int   busy_mode  = 0;     // 0: respond to tx_start, 1: force busy_force
    logic busy_force = 1'b0;
    int   busy_len   = 10;
    int   busy_cnt   = 0;

    serial_tx_feeder #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_timeout (tx_timeout)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Behavioural transmitter: busy for busy_len cycles after a sampled start.
    always @(posedge clk) begin
        if (busy_mode == 0) begin
            if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else if (busy_cnt == 1) begin
                busy_cnt <= 0;
                tx_busy  <= 1'b0;
            end else if (tx_start) begin
                busy_cnt <= busy_len;
                tx_busy  <= 1'b1;
            end else begin
                tx_busy <= 1'b0;
            end
        end else begin
            tx_busy <= busy_force;
        end
    end

    // Output monitor: scoreboard compare on each start, data hold while busy.
    always @(negedge clk) begin
        if (int'(count) > max_count) max_count = int'(count);
        if (rst) begin
            last_data = 8'h00;
        end else begin
            if (tx_start) begin
                assert_count++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("FAIL mon_unexpected_start: got tx_data=%02h with empty scoreboard", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        fail_count++;
                        $display("FAIL mon_tx_data: got %02h expected %02h", tx_data, e);
                    end
                end
                assert_count++;
                if (tx_busy !== 1'b0) begin
                    fail_count++;
                    $display("FAIL mon_start_while_busy: tx_busy=%0b expected 0", tx_busy);
                end
                start_count++;
                last_data = tx_data;
            end else if (tx_busy) begin
                if (tx_data !== last_data) begin
                    assert_count++;
                    fail_count++;
                    $display("FAIL mon_data_hold: got %02h expected %02h", tx_data, last_data);
                end
            end
        end
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait until scoreboard drained and transmitter quiet; ok=0 on expiry.
    task automatic wait_idle(input int max_cyc, output bit ok);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !tx_busy && !tx_start) quiet++;
            else quiet = 0;
        end
        ok = (quiet >= 6);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        repeat (3) @(negedge clk);
        assert_count++;
        if (count !== 5'd0) begin fail_count++; $display("FAIL reset_wr_ignored: count=%0d expected 0", count); end
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        assert_count++;
        if (empty !== 1'b1) begin fail_count++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        assert_count++;
        if (full !== 1'b0) begin fail_count++; $display("FAIL reset_full: got %0b expected 0", full); end
        assert_count++;
        if (overflow !== 1'b0 || tx_timeout !== 1'b0) begin fail_count++; $display("FAIL reset_flags: ovf=%0b to=%0b expected 0 0", overflow, tx_timeout); end
        assert_count++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00) begin fail_count++; $display("FAIL reset_tx: start=%0b data=%02h expected 0 00", tx_start, tx_data); end
    endtask

    task automatic test_single_byte();
        int s0;
        bit ok;
        busy_mode = 0; busy_len = 10;
        s0 = start_count;
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        @(negedge clk);
        wr_en = 1'b0;
        assert_count++;
        if (count !== 5'd1 || empty !== 1'b0 || tx_start !== 1'b0) begin
            fail_count++; $display("FAIL single_after_write: count=%0d empty=%0b start=%0b expected 1 0 0", count, empty, tx_start);
        end
        @(negedge clk);
        assert_count++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
            fail_count++; $display("FAIL single_latency: start=%0b data=%02h expected 1 55", tx_start, tx_data);
        end
        assert_count++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            fail_count++; $display("FAIL single_popped: empty=%0b count=%0d expected 1 0", empty, count);
        end
        @(negedge clk);
        assert_count++;
        if (tx_start !== 1'b0) begin fail_count++; $display("FAIL single_pulse_width: start=%0b expected 0", tx_start); end
        wait_idle(100, ok);
        assert_count++;
        if (ok !== 1'b1) begin fail_count++; $display("FAIL single_drain: ok=%0b expected 1", ok); end
        assert_count++;
        if (start_count - s0 != 1 || empty !== 1'b1) begin
            fail_count++; $display("FAIL single_starts: starts=%0d empty=%0b expected 1 1", start_count - s0, empty);
        end
    endtask

    task automatic test_burst();
        int s0;
        bit ok;
        busy_mode = 0; busy_len = 3;
        s0 = start_count;
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        assert_count++;
        if (overflow !== 1'b0) begin fail_count++; $display("FAIL burst_no_overflow: got %0b expected 0", overflow); end
        wait_idle(2000, ok);
        assert_count++;
        if (ok !== 1'b1) begin fail_count++; $display("FAIL burst_drain: ok=%0b expected 1", ok); end
        assert_count++;
        if (start_count - s0 != 16) begin fail_count++; $display("FAIL burst_starts: got %0d expected 16", start_count - s0); end
        assert_count++;
        if (empty !== 1'b1 || count !== 5'd0) begin fail_count++; $display("FAIL burst_empty: empty=%0b count=%0d expected 1 0", empty, count); end
    endtask

    task automatic test_overflow();
        int s0;
        bit ok;
        busy_mode = 1; busy_force = 1'b1;
        @(negedge clk);
        s0 = start_count;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            if (i < 16) exp_q.push_back(8'h20 + 8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        assert_count++;
        if (count !== 5'd16 || full !== 1'b1) begin fail_count++; $display("FAIL ovf_full: count=%0d full=%0b expected 16 1", count, full); end
        assert_count++;
        if (overflow !== 1'b1) begin fail_count++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        assert_count++;
        if (start_count != s0) begin fail_count++; $display("FAIL ovf_start_while_busy: starts=%0d expected 0", start_count - s0); end
        busy_mode = 0; busy_len = 2;
        wait_idle(2000, ok);
        assert_count++;
        if (ok !== 1'b1 || start_count - s0 != 16) begin fail_count++; $display("FAIL ovf_drain: ok=%0b starts=%0d expected 1 16", ok, start_count - s0); end
        assert_count++;
        if (overflow !== 1'b1 || full !== 1'b0) begin fail_count++; $display("FAIL ovf_sticky: ovf=%0b full=%0b expected 1 0", overflow, full); end
    endtask

    task automatic test_wrap();
        int s0;
        bit ok;
        busy_mode = 0; busy_len = 2;
        s0 = start_count;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(4, 10)) @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(i * 7 + 3); exp_q.push_back(8'(i * 7 + 3));
            @(negedge clk);
            wr_en = 1'b0;
        end
        wait_idle(3000, ok);
        assert_count++;
        if (ok !== 1'b1 || start_count - s0 != 40) begin fail_count++; $display("FAIL wrap_drain: ok=%0b starts=%0d expected 1 40", ok, start_count - s0); end
        assert_count++;
        if (max_count > 16) begin fail_count++; $display("FAIL wrap_max_count: got %0d expected <=16", max_count); end
    endtask

    task automatic test_timeout();
        int s0;
        int n;
        bit ok;
        busy_mode = 1; busy_force = 1'b0;
        @(negedge clk);
        s0 = start_count;
        assert_count++;
        if (tx_timeout !== 1'b0) begin fail_count++; $display("FAIL to_initial: got %0b expected 0", tx_timeout); end
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        while (tx_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        assert_count++;
        if (tx_start !== 1'b1) begin fail_count++; $display("FAIL to_start: start=%0b expected 1", tx_start); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            assert_count++;
            if (tx_timeout !== 1'b0) begin fail_count++; $display("FAIL to_early: cycle %0d timeout=%0b expected 0", k, tx_timeout); end
        end
        @(negedge clk);
        assert_count++;
        if (tx_timeout !== 1'b1) begin fail_count++; $display("FAIL to_set: got %0b expected 1", tx_timeout); end
        busy_mode = 0; busy_len = 3;
        wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(200, ok);
        assert_count++;
        if (ok !== 1'b1 || start_count - s0 != 2) begin fail_count++; $display("FAIL to_next_byte: ok=%0b starts=%0d expected 1 2", ok, start_count - s0); end
        assert_count++;
        if (tx_timeout !== 1'b1) begin fail_count++; $display("FAIL to_sticky: got %0b expected 1", tx_timeout); end
    endtask

    task automatic test_reset_mid();
        int s0;
        int n;
        bit ok;
        busy_mode = 0; busy_len = 20;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h90 + 8'(i); exp_q.push_back(8'h90 + 8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        n = 0;
        while (tx_busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        assert_count++;
        if (tx_busy !== 1'b1 || count !== 5'd5) begin fail_count++; $display("FAIL rstmid_setup: busy=%0b count=%0d expected 1 5", tx_busy, count); end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        assert_count++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin fail_count++; $display("FAIL rstmid_fifo: count=%0d empty=%0b full=%0b expected 0 1 0", count, empty, full); end
        assert_count++;
        if (tx_start !== 1'b0 || overflow !== 1'b0 || tx_timeout !== 1'b0 || tx_data !== 8'h00) begin
            fail_count++; $display("FAIL rstmid_outputs: start=%0b ovf=%0b to=%0b data=%02h expected 0 0 0 00", tx_start, overflow, tx_timeout, tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        s0 = start_count;
        wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        while (tx_busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
        assert_count++;
        if (tx_busy !== 1'b0 || start_count != s0 || tx_start !== 1'b0) begin
            fail_count++; $display("FAIL rstmid_wait_busy: busy=%0b starts=%0d start=%0b expected 0 0 0", tx_busy, start_count - s0, tx_start);
        end
        wait_idle(200, ok);
        assert_count++;
        if (ok !== 1'b1 || start_count - s0 != 1) begin fail_count++; $display("FAIL rstmid_resume: ok=%0b starts=%0d expected 1 1", ok, start_count - s0); end
    endtask

    // Test sequence
    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/serial_tx_feeder.md
SERIAL_TX_FEEDER -- requirements
Module: serial_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO depth (16 bytes).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4, max cycles to wait for tx_busy rise after a start.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write strobe, one byte per cycle.
REQ-006 SHALL have port wr_data  input  8  byte to queue.
REQ-007 SHALL have port full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port count  output  DEPTH_LOG2+1  bytes currently queued.
REQ-010 SHALL have port overflow  output  1  sticky: a write was dropped.
REQ-011 SHALL have port tx_start  output  1  one-cycle pulse to the serial transmitter.
REQ-012 SHALL have port tx_data  output  8  byte to the transmitter, stable from tx_start until tx_busy falls.
REQ-013 SHALL have port tx_busy  input  1  transmitter busy; rises the cycle after an accepted start.
REQ-014 SHALL have port tx_timeout  output  1  sticky: tx_busy failed to rise within BUSY_TIMEOUT cycles.

Function
REQ-015 SHALL implement a circular FIFO with read/write pointers of DEPTH_LOG2 bits, wrapping modulo depth.
REQ-016 SHALL accept a write when wr_en=1 and full=0; when full=1, SHALL drop the write and set overflow, even if a pop occurs in the same cycle.
REQ-017 On a simultaneous accepted write and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-018 full, empty and count SHALL be registered and reflect the state after the current edge's write/pop.
REQ-019 SHALL run an FSM with states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-020 In IDLE with empty=0 and tx_busy=0 at an edge, the block SHALL pop the head byte into tx_data, assert tx_start for exactly the next cycle, and enter WAIT_BUSY.
REQ-021 In IDLE, tx_start SHALL NOT assert while tx_busy=1 or empty=1.
REQ-022 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-023 In WAIT_BUSY, a cycle counter SHALL run; after BUSY_TIMEOUT cycles without tx_busy, the FSM SHALL set tx_timeout and return to IDLE, and the popped byte is lost.
REQ-024 In WAIT_DONE, tx_busy=0 SHALL return the FSM to IDLE.
REQ-025 Latency: a byte written into an empty FIFO at edge N while IDLE with tx_busy=0 SHALL produce tx_start high in cycle N+2 (count registered at N, pop at N+1).
REQ-026 Back-to-back queued bytes SHALL each produce exactly one tx_start, with no start while tx_busy=1 or in WAIT_BUSY/WAIT_DONE.
REQ-027 Write order SHALL equal tx_data order.
REQ-028 overflow and tx_timeout SHALL clear only on rst.

Reset
REQ-029 With rst=1 at an edge, SHALL set: pointers=0, count=0, empty=1, full=0, overflow=0, tx_timeout=0, tx_start=0, tx_data=0x00, FSM=IDLE, timeout counter=0.
REQ-030 Reset mid-transfer SHALL discard queued data; after reset the block SHALL wait in IDLE until tx_busy=0 before any new start.
REQ-031 wr_en during rst=1 SHALL be ignored.

Verification
REQ-032 Single byte: write 0x55 into empty FIFO, transmitter model busy 10 cycles -> one tx_start two cycles later, tx_data=0x55 held until busy falls, empty=1 afterwards.
REQ-033 Burst: write 0x01..0x10 on 16 consecutive cycles -> full=1 after the 16th write minus pops in flight; bytes emerge in order 0x01..0x10 with exactly 16 start pulses.
REQ-034 Overflow: hold tx_busy=1, write 17 bytes -> count=16, 17th dropped, overflow=1 and stays 1.
REQ-035 Wrap: push/pop 40 bytes with random gaps -> pointers wrap twice, output sequence matches input, count never exceeds 16.
REQ-036 Timeout: tx_busy tied 0, write 0xA5 -> one tx_start, tx_timeout=1 after 4 cycles in WAIT_BUSY, FSM back in IDLE, next byte still sent.
REQ-037 Reset mid-operation: assert rst with 5 bytes queued in WAIT_DONE -> next cycle count=0, tx_start=0, flags=0; no start until tx_busy=0.
